fht_control_gen: RTL and testbench

- Parametrised successor to the fixed 1024-point FHT sequencer.
- Sequences all log2(N) radix-2 FHT stages over four RAM banks of depth N/4, on one clock.
- Generates read/write/coefficient addresses, write enables, sector and subsector flags, and ping-pong bank select for the bank mixers and butterfly datapath.
- Sits between the host start/ready handshake and the bank RAMs/mixers.

---
 rtl/fht_gen_pkg.sv | 24 ++
 rtl/fht_addr_delay.sv | 27 ++
 rtl/fht_control_gen.sv | 196 +++++++++++++++++++
 tb/tb_fht_control_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_gen_pkg.sv
// Shared types and helpers for the parametrised FHT stage sequencer.
package fht_gen_pkg;

    typedef enum logic [1:0] {IDLE, RUN, NEXT} fsm_t;

    localparam int N_LOG2_DEF   = 10;
    localparam int PIPE_LAT_DEF = 2;

    function automatic int depth_of(input int n_log2);
        return 1 << (n_log2 - 2);
    endfunction

    function automatic int stage_len(input int n_log2, input int lat);
        return depth_of(n_log2) + lat + 1;
    endfunction

    // Reverse the low w bits of v: mirror all 16 bits, then drop the unused tail.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r >> (16 - w);
    endfunction

endpackage

// File: rtl/fht_addr_delay.sv
// Butterfly-latency delay line for the lane-0 counter and the second-half flag.
module fht_addr_delay #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic         iCLK,
    input  logic         iRESET,
    input  logic [W-1:0] cnt,
    input  logic         half,
    output logic [W-1:0] cnt_dly,
    output logic         half_dly
);

    logic [LAT-1:0][W:0] vld_pipe;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= {half, cnt};
            for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign {half_dly, cnt_dly} = vld_pipe[LAT-1];

endmodule

// File: rtl/fht_control_gen.sv
// Radix-2 FHT stage sequencer over four DEPTH-deep banks.
// Optional FHT_ABORT_EN adds iABORT to drop a run back to IDLE.
module fht_control_gen
    import fht_gen_pkg::*;
#(
    parameter int N_LOG2   = N_LOG2_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int A_BIT    = N_LOG2 - 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
`ifdef FHT_ABORT_EN
    input  logic             iABORT,
`endif
    output logic             oRDY,
    output logic             oBUSY,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             o2ND_PART_SUBSEC,
    output logic [A_BIT-1:0] oSECTOR,
    output logic [3:0]       oSTAGE,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA
);

    localparam int             DEPTH  = 1 << A_BIT;
    localparam int             TW     = A_BIT + 4;
    localparam logic [TW-1:0]  T_LAST = TW'(DEPTH + PIPE_LAT - 1);
    localparam logic [3:0]     S_LAST = 4'(N_LOG2 - 1);

    fsm_t            state, state_nxt;
    logic [3:0]      stage, stage_nxt;
    logic [TW-1:0]   t, t_nxt;
    logic            src, src_nxt;
    logic            rdy, we_a, we_b;

    logic            run_n, rd_win, wr_win, half_in, d_half;
    logic [3:0]      sh;
    logic [A_BIT:0]  div;
    logic [A_BIT-1:0] msk, hlf, rc, refl, d_cnt;
    logic [A_BIT-1:0] rd1_n, wr0_n, wr1_n, sec_n, coef_n;
    logic            we_a_n, we_b_n, half_n;
    logic [15:0]     rev;

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        t_nxt     = t;
        src_nxt   = src;
        case (state)
            IDLE: begin
                stage_nxt = '0;
                t_nxt     = '0;
                src_nxt   = 1'b0;
                if (iSTART) state_nxt = RUN;
            end
            RUN: begin
                if (t == T_LAST) begin
                    state_nxt = NEXT;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            NEXT: begin
                t_nxt = '0;
                if (stage == S_LAST) begin
                    state_nxt = IDLE;
                    stage_nxt = '0;
                    src_nxt   = 1'b0;
                end else begin
                    state_nxt = RUN;
                    stage_nxt = stage + 1'b1;
                    src_nxt   = ~src;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef FHT_ABORT_EN
        // Abort wins over the stage/run completion decode above.
        if (iABORT && state != IDLE) begin
            state_nxt = IDLE;
            stage_nxt = '0;
            t_nxt     = '0;
            src_nxt   = 1'b0;
        end
`endif
    end

    // Everything below is evaluated on next-cycle values so each output flop
    // lines up with the stage timer it is derived from.
    always_comb begin
        run_n  = (state_nxt == RUN);
        sh     = (stage_nxt <= 4'd1) ? 4'(A_BIT) : 4'(A_BIT + 1) - stage_nxt;
        div    = {{A_BIT{1'b0}}, 1'b1} << sh;
        msk    = div[A_BIT-1:0] - A_BIT'(1);
        hlf    = div[A_BIT:1];
        rd_win = run_n && (t_nxt < TW'(DEPTH));
        wr_win = run_n && (t_nxt >= TW'(PIPE_LAT)) && (t_nxt < TW'(DEPTH + PIPE_LAT));
        rc     = rd_win ? t_nxt[A_BIT-1:0] : '0;
        refl   = (rc & ~msk) | ((div[A_BIT-1:0] - (rc & msk)) & msk);
        rd1_n  = (stage_nxt == 4'd0) ? rc : refl;
        half_in = rd_win && (stage_nxt != 4'd0) && |(rc & hlf);

        sec_n = '0;
        if (run_n) sec_n = rd_win ? (rc >> sh) : oSECTOR;
        rev    = bitrev(16'(oSECTOR), A_BIT);
        coef_n = (run_n && stage_nxt != 4'd0 && t_nxt != '0) ? rev[A_BIT-1:0] : '0;

        wr0_n = wr_win ? d_cnt : '0;
        wr1_n = '0;
        if (wr_win)
            wr1_n = (stage_nxt == 4'd0 || stage_nxt == S_LAST) ? d_cnt : (d_cnt ^ hlf);
        we_b_n = wr_win & ~stage_nxt[0];
        we_a_n = wr_win & stage_nxt[0];
        half_n = wr_win & d_half;
    end

    fht_addr_delay #(
        .W   (A_BIT),
        .LAT (PIPE_LAT)
    ) u_dly (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .cnt      (rc),
        .half     (half_in),
        .cnt_dly  (d_cnt),
        .half_dly (d_half)
    );

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state            <= IDLE;
            stage            <= '0;
            t                <= '0;
            src              <= 1'b0;
            rdy              <= 1'b1;
            oSECTOR          <= '0;
            oADDR_RD_0       <= '0;
            oADDR_RD_1       <= '0;
            oADDR_WR_0       <= '0;
            oADDR_WR_1       <= '0;
            oADDR_COEF       <= '0;
            we_a             <= 1'b0;
            we_b             <= 1'b0;
            o2ND_PART_SUBSEC <= 1'b0;
        end else begin
            state            <= state_nxt;
            stage            <= stage_nxt;
            t                <= t_nxt;
            src              <= src_nxt;
            rdy              <= (state_nxt == IDLE);
            oSECTOR          <= sec_n;
            oADDR_RD_0       <= rc;
            oADDR_RD_1       <= rd1_n;
            oADDR_WR_0       <= wr0_n;
            oADDR_WR_1       <= wr1_n;
            oADDR_COEF       <= coef_n;
            we_a             <= we_a_n;
            we_b             <= we_b_n;
            o2ND_PART_SUBSEC <= half_n;
        end
    end

    assign oRDY         = rdy;
    assign oBUSY        = ~rdy;
    assign oSTAGE       = stage;
    assign oSOURCE_DATA = src;
    assign oST_ZERO     = (state != IDLE) && (stage == 4'd0);
    assign oST_LAST     = (state != IDLE) && (stage == S_LAST);
    assign oADDR_RD_2   = oADDR_RD_0;
    assign oADDR_RD_3   = oADDR_RD_1;
    assign oADDR_WR_2   = oADDR_WR_0;
    assign oADDR_WR_3   = oADDR_WR_1;

`ifdef FHT_ABORT_EN
    // Kill the write strobes in the abort cycle itself.
    assign oWE_A = we_a & ~iABORT;
    assign oWE_B = we_b & ~iABORT;
`else
    assign oWE_A = we_a;
    assign oWE_B = we_b;
`endif

endmodule

// File: tb/tb_fht_control_gen.sv
// Directed bench for fht_control_gen (N=1024, PIPE_LAT=2; abort case at N=64).
module tb_fht_control_gen;

    localparam int AB = 8;
    localparam int DEPTH = 256;
    localparam int L = DEPTH + 2 + 1;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic iRESET, iSTART;
    logic rdy, busy, st_zero, st_last, half, we_a, we_b, src;
    logic [AB-1:0] sector, rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef;
    logic [3:0] stage;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    fht_control_gen #(.N_LOG2(10), .PIPE_LAT(2)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
`ifdef FHT_ABORT_EN
        .iABORT(1'b0),
`endif
        .oRDY(rdy), .oBUSY(busy), .oST_ZERO(st_zero), .oST_LAST(st_last),
        .o2ND_PART_SUBSEC(half), .oSECTOR(sector), .oSTAGE(stage),
        .oADDR_RD_0(rd0), .oADDR_RD_1(rd1), .oADDR_RD_2(rd2), .oADDR_RD_3(rd3),
        .oADDR_WR_0(wr0), .oADDR_WR_1(wr1), .oADDR_WR_2(wr2), .oADDR_WR_3(wr3),
        .oADDR_COEF(coef), .oWE_A(we_a), .oWE_B(we_b), .oSOURCE_DATA(src)
    );

`ifdef FHT_ABORT_EN
    logic a_rst, a_start, a_abort;
    logic a_rdy, a_busy, a_stz, a_stl, a_half, a_we_a, a_we_b, a_src;
    logic [3:0] a_sec, a_rd0, a_rd1, a_rd2, a_rd3, a_wr0, a_wr1, a_wr2, a_wr3, a_coef;
    logic [3:0] a_stage;

    fht_control_gen #(.N_LOG2(6), .PIPE_LAT(2)) dut_a (
        .iCLK(iCLK), .iRESET(a_rst), .iSTART(a_start), .iABORT(a_abort),
        .oRDY(a_rdy), .oBUSY(a_busy), .oST_ZERO(a_stz), .oST_LAST(a_stl),
        .o2ND_PART_SUBSEC(a_half), .oSECTOR(a_sec), .oSTAGE(a_stage),
        .oADDR_RD_0(a_rd0), .oADDR_RD_1(a_rd1), .oADDR_RD_2(a_rd2), .oADDR_RD_3(a_rd3),
        .oADDR_WR_0(a_wr0), .oADDR_WR_1(a_wr1), .oADDR_WR_2(a_wr2), .oADDR_WR_3(a_wr3),
        .oADDR_COEF(a_coef), .oWE_A(a_we_a), .oWE_B(a_we_b), .oSOURCE_DATA(a_src)
    );
`endif

    task automatic start_run;
        @(negedge iCLK); iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0;
        cyc = 0;
    endtask

    task automatic goto(input int s, input int tt);
        while (cyc < s * L + tt) begin
            @(negedge iCLK);
            cyc++;
        end
    endtask

    task automatic wait_idle;
        int k = 0;
        while (rdy !== 1'b1 && k < 4000) begin
            @(negedge iCLK);
            k++;
            cyc++;
        end
        n_chk++;
        if (rdy !== 1'b1) begin
            $display("FAIL wait_idle: oRDY=%b, required 1 within 4000 cycles", rdy);
            n_err++;
        end
    endtask

    task automatic test_reset;
        iSTART = 1'b0;
        iRESET = 1'b0;
`ifdef FHT_ABORT_EN
        a_start = 1'b0; a_abort = 1'b0; a_rst = 1'b0;
        #1 a_rst = 1'b1;
`endif
        #1 iRESET = 1'b1;
        repeat (3) @(negedge iCLK);
        iRESET = 1'b0;
`ifdef FHT_ABORT_EN
        a_rst = 1'b0;
`endif
        repeat (20) @(negedge iCLK);
        n_chk++; if (rdy !== 1'b1) begin $display("FAIL reset_rdy: got %b want 1", rdy); n_err++; end
        n_chk++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
        n_chk++;
        if ({rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef, sector} !== '0) begin
            $display("FAIL reset_addr: rd %0d %0d %0d %0d wr %0d %0d %0d %0d coef %0d sec %0d, want all 0",
                     rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef, sector);
            n_err++;
        end
        n_chk++;
        if ({we_a, we_b, src, st_zero, st_last, half, stage} !== '0) begin
            $display("FAIL reset_flags: we_a %b we_b %b src %b stz %b stl %b half %b stage %0d, want 0",
                     we_a, we_b, src, st_zero, st_last, half, stage);
            n_err++;
        end
    endtask

    task automatic test_run_length;
        int nbusy = 0, tog = 0, bad = 0;
        logic prev;
        start_run;
        prev = src;
        while (rdy === 1'b0 && nbusy < 5000) begin
            if (stage !== 4'(cyc / L)) bad++;
            if (st_last !== (cyc / L == 9)) bad++;
            if (st_zero !== (cyc / L == 0)) bad++;
            @(negedge iCLK);
            cyc++;
            nbusy++;
            if (src !== prev) tog++;
            prev = src;
        end
        n_chk++; if (nbusy != 2590) begin $display("FAIL run_length: busy %0d cycles want 2590", nbusy); n_err++; end
        n_chk++; if (tog != 10) begin $display("FAIL src_toggles: got %0d want 10", tog); n_err++; end
        n_chk++; if (bad != 0) begin $display("FAIL stage_seq: %0d bad stage/flag samples want 0", bad); n_err++; end
        n_chk++; if (src !== 1'b0) begin $display("FAIL src_idle: got %b want 0", src); n_err++; end
    endtask

    task automatic test_read_addr;
        start_run;
        goto(0, 10);
        n_chk++; if (rd1 !== 8'd10) begin $display("FAIL rd1_stage0: got %0d want 10", rd1); n_err++; end
        goto(2, 5);
        n_chk++; if (rd0 !== 8'd5 || rd2 !== 8'd5) begin $display("FAIL rd0_s2: got %0d/%0d want 5", rd0, rd2); n_err++; end
        n_chk++; if (rd1 !== 8'd123 || rd3 !== 8'd123) begin $display("FAIL rd1_s2: got %0d/%0d want 123", rd1, rd3); n_err++; end
        goto(2, 256);
        n_chk++; if (rd0 !== 8'd0 || rd1 !== 8'd0) begin $display("FAIL rd_window: got %0d/%0d want 0", rd0, rd1); n_err++; end
        goto(9, 5);
        n_chk++; if (rd1 !== 8'd5) begin $display("FAIL rd1_last: got %0d want 5", rd1); n_err++; end
        wait_idle;
    endtask

    task automatic test_write_addr;
        start_run;
        goto(0, 1);
        n_chk++; if (we_b !== 1'b0) begin $display("FAIL we_before_window: got %b want 0", we_b); n_err++; end
        goto(0, 2);
        n_chk++; if (we_b !== 1'b1 || wr0 !== 8'd0) begin $display("FAIL we_first: we_b %b wr0 %0d want 1/0", we_b, wr0); n_err++; end
        goto(0, 20);
        n_chk++; if (wr0 !== 8'd18 || wr1 !== 8'd18) begin $display("FAIL wr_stage0: got %0d/%0d want 18/18", wr0, wr1); n_err++; end
        goto(2, 7);
        n_chk++; if (wr0 !== 8'd5 || wr2 !== 8'd5) begin $display("FAIL wr0_s2: got %0d/%0d want 5", wr0, wr2); n_err++; end
        n_chk++; if (wr1 !== 8'd69 || wr3 !== 8'd69) begin $display("FAIL wr1_s2: got %0d/%0d want 69", wr1, wr3); n_err++; end
        n_chk++; if (we_b !== 1'b1 || we_a !== 1'b0) begin $display("FAIL we_even: a %b b %b want 0/1", we_a, we_b); n_err++; end
        goto(2, 65);
        n_chk++; if (half !== 1'b0) begin $display("FAIL half_first: got %b want 0", half); n_err++; end
        goto(2, 66);
        n_chk++; if (half !== 1'b1) begin $display("FAIL half_second: got %b want 1", half); n_err++; end
        goto(3, 2);
        n_chk++; if (we_a !== 1'b1 || we_b !== 1'b0) begin $display("FAIL we_odd: a %b b %b want 1/0", we_a, we_b); n_err++; end
        goto(3, 258);
        n_chk++; if (we_a !== 1'b0 || we_b !== 1'b0) begin $display("FAIL we_next: a %b b %b want 0/0", we_a, we_b); n_err++; end
        goto(9, 5);
        n_chk++; if (wr0 !== 8'd3 || wr1 !== 8'd3) begin $display("FAIL wr_last: got %0d/%0d want 3/3", wr0, wr1); n_err++; end
        goto(9, 257);
        n_chk++; if (wr0 !== 8'd255) begin $display("FAIL wr_final: got %0d want 255", wr0); n_err++; end
        wait_idle;
    endtask

    task automatic test_coef;
        int bad = 0;
        start_run;
        while (cyc < L) begin
            if (coef !== 8'd0 || half !== 1'b0) bad++;
            @(negedge iCLK);
            cyc++;
        end
        n_chk++; if (bad != 0) begin $display("FAIL coef_stage0: %0d nonzero samples want 0", bad); n_err++; end
        goto(3, 100);
        n_chk++; if (sector !== 8'd1) begin $display("FAIL sector_s3: got %0d want 1", sector); n_err++; end
        n_chk++; if (coef !== 8'd128) begin $display("FAIL coef_s3: got %0d want 128", coef); n_err++; end
        goto(9, 37);
        n_chk++; if (sector !== 8'd37) begin $display("FAIL sector_last: got %0d want 37", sector); n_err++; end
        goto(9, 38);
        n_chk++; if (coef !== 8'd164) begin $display("FAIL coef_last: got %0d want 164", coef); n_err++; end
        wait_idle;
    endtask

    task automatic test_busy_reset;
        @(negedge iCLK); iSTART = 1'b1;
        @(negedge iCLK); cyc = 0;
        goto(4, 50);
        n_chk++; if (stage !== 4'd4 || rd0 !== 8'd50) begin $display("FAIL start_ignored: stage %0d rd0 %0d want 4/50", stage, rd0); n_err++; end
        n_chk++; if (rd1 !== 8'd46) begin $display("FAIL rd1_s4: got %0d want 46", rd1); n_err++; end
        #2 iRESET = 1'b1;
        #1;
        n_chk++; if (rdy !== 1'b1 || busy !== 1'b0) begin $display("FAIL async_rdy: rdy %b busy %b want 1/0", rdy, busy); n_err++; end
        n_chk++;
        if ({rd0, rd1, wr0, wr1, coef, sector, stage, we_a, we_b, src, st_zero, half} !== '0) begin
            $display("FAIL async_clear: rd0 %0d rd1 %0d coef %0d sec %0d stage %0d src %b, want 0",
                     rd0, rd1, coef, sector, stage, src);
            n_err++;
        end
        iSTART = 1'b0;
        @(negedge iCLK); iRESET = 1'b0;
        repeat (2) @(negedge iCLK);
        n_chk++; if (rdy !== 1'b1) begin $display("FAIL post_reset_idle: got %b want 1", rdy); n_err++; end
    endtask

    task automatic test_back_to_back;
        start_run;
        goto(9, L - 1);
        n_chk++; if (st_last !== 1'b1 || busy !== 1'b1) begin $display("FAIL last_next: stl %b busy %b want 1/1", st_last, busy); n_err++; end
        iSTART = 1'b1;
        @(negedge iCLK);
        n_chk++; if (rdy !== 1'b1) begin $display("FAIL completion_idle: rdy %b want 1", rdy); n_err++; end
        @(negedge iCLK);
        iSTART = 1'b0;
        n_chk++; if (busy !== 1'b1 || stage !== 4'd0) begin $display("FAIL restart: busy %b stage %0d want 1/0", busy, stage); n_err++; end
        @(negedge iCLK);
        n_chk++; if (rd0 !== 8'd1) begin $display("FAIL restart_t: rd0 %0d want 1", rd0); n_err++; end
        iRESET = 1'b1;
        @(negedge iCLK); iRESET = 1'b0;
        @(negedge iCLK);
    endtask

`ifdef FHT_ABORT_EN
    task automatic test_abort;
        int bad = 0;
        @(negedge iCLK); a_start = 1'b1;
        @(negedge iCLK); a_start = 1'b0;
        repeat (2 * 19 + 7) @(negedge iCLK);
        n_chk++; if (a_stage !== 4'd2 || a_we_b !== 1'b1) begin $display("FAIL abort_pre: stage %0d we_b %b want 2/1", a_stage, a_we_b); n_err++; end
        a_abort = 1'b1;
        #1;
        n_chk++; if (a_we_a !== 1'b0 || a_we_b !== 1'b0) begin $display("FAIL abort_we: a %b b %b want 0/0", a_we_a, a_we_b); n_err++; end
        @(negedge iCLK); a_abort = 1'b0;
        n_chk++; if (a_rdy !== 1'b1) begin $display("FAIL abort_idle: rdy %b want 1", a_rdy); n_err++; end
        repeat (60) begin
            if (a_we_a !== 1'b0 || a_we_b !== 1'b0) bad++;
            @(negedge iCLK);
        end
        n_chk++; if (bad != 0) begin $display("FAIL abort_no_write: %0d WE samples want 0", bad); n_err++; end
        @(negedge iCLK); a_start = 1'b1;
        @(negedge iCLK); a_start = 1'b0;
        n_chk++; if (a_busy !== 1'b1 || a_stage !== 4'd0 || a_rd0 !== 4'd0) begin
            $display("FAIL abort_restart: busy %b stage %0d rd0 %0d want 1/0/0", a_busy, a_stage, a_rd0); n_err++;
        end
        repeat (3) @(negedge iCLK);
        n_chk++; if (a_rd0 !== 4'd3) begin $display("FAIL abort_restart_t: rd0 %0d want 3", a_rd0); n_err++; end
    endtask
`endif

    initial begin
        test_reset;
        test_run_length;
        test_read_addr;
        test_write_addr;
        test_coef;
        test_busy_reset;
        test_back_to_back;
`ifdef FHT_ABORT_EN
        test_abort;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
